// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences core reset, watches tohost stores, halts and timeouts, and reports the test verdict
module sim_run_ctrl #(
  parameter int              AW             = 6,
  parameter int              DW             = 64,
  parameter int              RESET_CYCLES   = 3,
  parameter int              TIMEOUT_CYCLES = 120,
  parameter logic [AW-1:0]   TOHOST_ADDR    = 6'h3F,
  parameter int              HALT_REPEAT    = 4,
  parameter int              CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  output logic             core_rst_n,
  input  logic [AW-1:0]    i_mem_addr,
  input  logic             d_mem_we,
  input  logic [AW-1:0]    d_mem_addr,
  input  logic [DW-1:0]    d_mem_data,
  output logic             done,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count,
  output logic [DW-1:0]    result_data
);
  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0]       REP_LAST  = 8'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       rep_q, rep_d;
  logic [AW-1:0]    prev_q, prev_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] st_q, st_d;
  logic [DW-1:0]    res_q, res_d;
  logic             tohost, same;

  // A zero repeat count marks an empty history, so the first RUN cycle never matches a stale address
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    prev_d  = prev_q;
    cyc_d   = cyc_q;
    st_d    = st_q;
    res_d   = res_q;
    tohost  = d_mem_we && d_mem_addr == TOHOST_ADDR;
    same    = rep_q != 8'd0 && i_mem_addr == prev_q;
    case (state_q)
      HOLD: begin
        hold_d  = hold_q + 8'd1;
        rep_d   = 8'd0;
        state_d = hold_q == HOLD_LAST ? RUN : HOLD;
      end
      RUN: begin
        prev_d = i_mem_addr;
        rep_d  = same ? rep_q + 8'd1 : 8'd1;
        st_d   = d_mem_we && !tohost && st_q != '1 ? st_q + 1'b1 : st_q;
        if (tohost) begin
          res_d   = d_mem_data;
          state_d = d_mem_data == DW'(1) ? PASS : FAIL;
        end else if (same && rep_q == REP_LAST) state_d = HALT;
        else if (cyc_q == TO_LAST) state_d = TIMEOUT;
        else cyc_d = cyc_q + 1'b1;
      end
      default: if (restart) begin
        state_d = HOLD;
        hold_d  = 8'd0;
        rep_d   = 8'd0;
        cyc_d   = '0;
        st_d    = '0;
        res_d   = '0;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      hold_q  <= '0;
      rep_q   <= '0;
      prev_q  <= '0;
      cyc_q   <= '0;
      st_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      cyc_q   <= cyc_d;
      st_q    <= st_d;
      res_q   <= res_d;
    end
  end

  assign status      = state_q;
  assign done        = state_q inside {PASS, FAIL, TIMEOUT, HALT};
  assign core_rst_n  = state_q == RUN;
  assign cycle_count = cyc_q;
  assign store_count = st_q;
  assign result_data = res_q;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed checks of hold, pass/fail, timeout, halt, restart and reset behaviour
module tb_sim_run_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        core_rst_n;
  logic [5:0]  i_mem_addr = 6'h10;
  logic        d_mem_we = 1'b0;
  logic [5:0]  d_mem_addr = 6'h00;
  logic [63:0] d_mem_data = 64'h0;
  logic        done;
  logic [2:0]  status;
  logic [15:0] cycle_count, store_count;
  logic [63:0] result_data;
  logic        vary = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;

  sim_run_ctrl dut (
    .clk(clk), .reset(reset), .restart(restart), .core_rst_n(core_rst_n),
    .i_mem_addr(i_mem_addr), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr),
    .d_mem_data(d_mem_data), .done(done), .status(status),
    .cycle_count(cycle_count), .store_count(store_count), .result_data(result_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (vary) i_mem_addr = i_mem_addr + 6'd1;
    end
  endtask

  task automatic store(input logic [5:0] a, input logic [63:0] d);
    d_mem_we = 1'b1;
    d_mem_addr = a;
    d_mem_data = d;
    cyc(1);
    d_mem_we = 1'b0;
  endtask

  task automatic do_restart;
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
  endtask

  initial begin
    cyc(2);
    check("rst_status", status, 0);
    check("rst_done", done, 0);
    check("rst_core", core_rst_n, 0);
    check("rst_cycles", cycle_count, 0);
    reset = 1'b0;
    check("hold0_core", core_rst_n, 0);
    cyc(1);
    check("hold1_core", core_rst_n, 0);
    cyc(1);
    check("hold2_core", core_rst_n, 0);
    cyc(1);
    check("run_core", core_rst_n, 1);
    check("run_status", status, 1);
    check("run_cycles0", cycle_count, 0);

    cyc(10);
    check("run_cycles10", cycle_count, 10);
    store(6'h3F, 64'h1);
    check("pass_status", status, 2);
    check("pass_done", done, 1);
    check("pass_result", result_data, 1);
    check("pass_cycles", cycle_count, 10);
    check("pass_core", core_rst_n, 0);
    cyc(3);
    check("pass_hold_status", status, 2);
    check("pass_hold_cycles", cycle_count, 10);

    do_restart();
    check("rs_status", status, 0);
    check("rs_cycles", cycle_count, 0);
    check("rs_result", result_data, 0);
    cyc(3);
    store(6'h05, 64'h7);
    cyc(1);
    store(6'h05, 64'h9);
    cyc(1);
    check("st_count", store_count, 2);
    check("st_cycles", cycle_count, 4);
    store(6'h3F, 64'h2A);
    check("fail_status", status, 3);
    check("fail_result", result_data, 64'h2A);
    d_mem_we = 1'b1;
    d_mem_addr = 6'h05;
    cyc(2);
    d_mem_we = 1'b0;
    check("fail_st_frozen", store_count, 2);

    do_restart();
    check("rs2_store", store_count, 0);
    cyc(3);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("run_ignore_restart", status, 1);
    check("run_ignore_cycles", cycle_count, 1);
    cyc(118);
    check("pre_to_status", status, 1);
    check("pre_to_cycles", cycle_count, 119);
    cyc(1);
    check("to_status", status, 4);
    check("to_cycles", cycle_count, 119);
    check("to_done", done, 1);

    i_mem_addr = 6'h10;
    do_restart();
    cyc(3);
    cyc(5);
    vary = 1'b0;
    i_mem_addr = 6'h08;
    cyc(3);
    check("halt_pre_status", status, 1);
    check("halt_pre_cycles", cycle_count, 8);
    cyc(1);
    check("halt_status", status, 5);
    check("halt_cycles", cycle_count, 8);
    do_restart();
    check("rs3_status", status, 0);
    check("rs3_cycles", cycle_count, 0);
    check("rs3_core", core_rst_n, 0);
    cyc(2);
    check("rs3_hold", status, 0);
    cyc(1);
    check("rs3_run", status, 1);
    cyc(3);
    check("fresh_pre_halt", status, 1);
    cyc(1);
    check("fresh_halt", status, 5);
    check("fresh_halt_cycles", cycle_count, 3);

    vary = 1'b1;
    i_mem_addr = 6'h10;
    do_restart();
    cyc(3);
    cyc(119);
    check("tie_cycles", cycle_count, 119);
    store(6'h3F, 64'h1);
    check("tie_pass", status, 2);
    do_restart();
    cyc(3);
    cyc(119);
    store(6'h3F, 64'h5);
    check("tie_fail", status, 3);
    check("tie_fail_result", result_data, 5);
    check("tie_fail_cycles", cycle_count, 119);

    do_restart();
    cyc(3);
    cyc(5);
    check("mid_cycles", cycle_count, 5);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_status", status, 0);
    check("mid_rst_core", core_rst_n, 0);
    check("mid_rst_cycles", cycle_count, 0);
    #1;
    reset = 1'b0;
    cyc(2);
    check("mid_hold", status, 0);
    cyc(1);
    check("mid_run", status, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
